// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage driving a combinational instruction ROM into a
//            2-entry {pc, instr} queue drained by decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] C_DEPTH = 2'd2;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_fault;
    logic [31:0] r_fetch_count;

    logic        w_pop;
    logic        w_push;

    assign imem_addr   = r_fetch_pc;
    assign out_valid   = (r_count != 2'd0);
    assign out_pc      = r_q_pc[r_rd_ptr];
    assign out_instr   = r_q_instr[r_rd_ptr];
    assign fetch_fault = r_fault;
    assign fetch_count = r_fetch_count;

    assign w_pop  = out_valid & out_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign w_push = ~r_fault & ~redirect_valid & ((r_count != C_DEPTH) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            // A pop coincident with a redirect is still a completed handshake.
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                r_count    <= 2'd0;
                r_rd_ptr   <= r_wr_ptr;
                r_fetch_pc <= redirect_pc;
                r_fault    <= (redirect_pc[1:0] != 2'b00);
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= ~r_wr_ptr;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload needs no reset: entries are only observed once count says valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= imem_instr;
        end
    end

endmodule
`default_nettype wire
